// File: rtl/tpu_pkg.sv
// tpu_pkg: opcode and sequencer-state types shared by the TPU sequencer files.
package tpu_pkg;
    localparam int OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        HALT        = 3'b000,
        LOAD_ADDR   = 3'b001,
        LOAD_WEIGHT = 3'b010,
        LOAD_INPUTS = 3'b011,
        COMPUTE     = 3'b100,
        STORE       = 3'b101,
        NOP         = 3'b110,
        ILLEGAL     = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, DONE, ERROR} seq_state_t;
endpackage

// File: rtl/tpu_sequencer_if.sv
// tpu_sequencer_if: host/program and datapath strobe bundle of the sequencer.
// perf_cycles exists only when TPU_SEQ_PERF_EN is defined.
interface tpu_sequencer_if #(
    parameter int INSTR_W    = 16,
    parameter int IMEM_DEPTH = 16,
    parameter int ADDR_W     = 13
);
    logic                          start;
    logic                          prog_we;
    logic [$clog2(IMEM_DEPTH)-1:0] prog_addr;
    logic [INSTR_W-1:0]            prog_data;
    logic                          stall;
    logic [ADDR_W-1:0]             base_address;
    logic                          load_weight;
    logic                          load_input;
    logic                          valid;
    logic                          store;
    logic                          busy;
    logic                          done;
    logic                          error;
`ifdef TPU_SEQ_PERF_EN
    logic [31:0]                   perf_cycles;
`endif

    modport master (
`ifdef TPU_SEQ_PERF_EN
        input  perf_cycles,
`endif
        output start, prog_we, prog_addr, prog_data, stall,
        input  base_address, load_weight, load_input, valid, store, busy, done, error
    );

    modport slave (
`ifdef TPU_SEQ_PERF_EN
        output perf_cycles,
`endif
        input  start, prog_we, prog_addr, prog_data, stall,
        output base_address, load_weight, load_input, valid, store, busy, done, error
    );
endinterface

// File: rtl/tpu_instr_mem.sv
// tpu_instr_mem: program memory, synchronous write, combinational read, not reset.
module tpu_instr_mem
    import tpu_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [INSTR_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [INSTR_W-1:0]       rdata
);
    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/tpu_sequencer.sv
// tpu_sequencer: programmable fetch/decode sequencer driving the TPU datapath strobes.
// Optional TPU_SEQ_PERF_EN adds a saturating busy-cycle counter (perf_cycles).
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int INSTR_W        = 16,
    parameter int IMEM_DEPTH     = 16,
    parameter int ADDR_W         = 13,
    parameter int COMPUTE_CYCLES = 6
) (
    input logic              clk,
    input logic              reset,
    tpu_sequencer_if.slave   bus
);
    localparam int PC_W  = $clog2(IMEM_DEPTH);
    localparam int IMM_W = INSTR_W - OPC_W;

    seq_state_t         state;
    logic [PC_W-1:0]    pc;
    logic [7:0]         cnt;
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] rd_data;
    logic [ADDR_W-1:0]  base_address;
    opcode_t            opc;
    logic [IMM_W-1:0]   imm;
    logic [7:0]         len;
    logic               busy;
    logic               exec;
    logic               go;
    logic               last;
    logic               pc_end;

    assign opc    = opcode_t'(instr[INSTR_W-1 -: OPC_W]);
    assign imm    = instr[IMM_W-1:0];
    assign len    = imm[7:0] == 8'd0 ? 8'(COMPUTE_CYCLES) : imm[7:0];
    assign exec   = state == EXEC;
    assign busy   = state == FETCH || exec;
    assign go     = bus.start && (state == IDLE || state == DONE || state == ERROR);
    assign last   = opc != COMPUTE || cnt == len - 8'd1;
    assign pc_end = pc == PC_W'(IMEM_DEPTH - 1);

    tpu_instr_mem #(.INSTR_W(INSTR_W), .DEPTH(IMEM_DEPTH)) u_mem (
        .clk  (clk),
        .we   (bus.prog_we && !busy),
        .waddr(bus.prog_addr),
        .wdata(bus.prog_data),
        .raddr(pc),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= IDLE;
            pc           <= '0;
            cnt          <= '0;
            instr        <= '0;
            base_address <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR:
                    if (go) begin
                        state <= FETCH;
                        pc    <= '0;
                    end
                FETCH: begin
                    instr <= rd_data;
                    state <= EXEC;
                end
                EXEC: begin
                    // rewriting the same immediate while stalled is indistinguishable from a single load
                    if (opc == LOAD_ADDR) base_address <= imm[ADDR_W-1:0];
                    if (!bus.stall) begin
                        if (opc == HALT) state <= DONE;
                        else if (opc == ILLEGAL) state <= ERROR;
                        else if (last) begin
                            cnt   <= '0;
                            pc    <= pc_end ? pc : pc + PC_W'(1);
                            state <= pc_end ? DONE : FETCH;
                        end else cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end

    assign bus.base_address = base_address;
    assign bus.load_weight  = exec && opc == LOAD_WEIGHT;
    assign bus.load_input   = exec && opc == LOAD_INPUTS;
    assign bus.valid        = exec && opc == COMPUTE;
    assign bus.store        = exec && opc == STORE;
    assign bus.busy         = busy;
    assign bus.done         = state == DONE;
    assign bus.error        = state == ERROR;

`ifdef TPU_SEQ_PERF_EN
    logic [31:0] perf_cycles;

    always_ff @(posedge clk or posedge reset)
        if (reset) perf_cycles <= '0;
        else if (go) perf_cycles <= '0;
        else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;

    assign bus.perf_cycles = perf_cycles;
`endif
endmodule

// File: tb/tb_tpu_sequencer.sv
// tb_tpu_sequencer: table-driven cycle traces for the TPU sequencer.
module tb_tpu_sequencer;
    import tpu_pkg::*;

    typedef struct {
        logic       stall;
        logic       we;
        logic [6:0] exp;
    } vec_t;

    localparam logic [6:0] Z  = 7'b0000000;
    localparam logic [6:0] B  = 7'b0000100;
    localparam logic [6:0] LW = 7'b1000100;
    localparam logic [6:0] LI = 7'b0100100;
    localparam logic [6:0] V  = 7'b0010100;
    localparam logic [6:0] ST = 7'b0001100;
    localparam logic [6:0] D  = 7'b0000010;
    localparam logic [6:0] E  = 7'b0000001;

    logic clk = 0;
    logic reset = 1;
    int   checks = 0;
    int   errors = 0;
    vec_t tv[$];

    tpu_sequencer_if bus();
    tpu_sequencer dut (.clk(clk), .reset(reset), .bus(bus.slave));

    logic [6:0] obs;
    assign obs = {bus.load_weight, bus.load_input, bus.valid, bus.store, bus.busy, bus.done, bus.error};

    always #5 clk = ~clk;

    function automatic logic [15:0] ins(opcode_t o, logic [12:0] i);
        return {o, i};
    endfunction

    function automatic void push(int n, logic s, logic [6:0] e, logic w = 1'b0);
        for (int i = 0; i < n; i++) tv.push_back('{stall: s, we: w, exp: e});
    endfunction

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic wr(int a, logic [15:0] d);
        bus.prog_addr = 4'(a);
        bus.prog_data = d;
        bus.prog_we   = 1;
        @(posedge clk);
        #1 bus.prog_we = 0;
    endtask

    task automatic run(string name, int n);
        int nb = 0;
        for (int i = 0; i < n; i++) begin
            bus.stall   = tv[i].stall;
            bus.prog_we = tv[i].we;
            @(posedge clk);
            #1;
            bus.start   = 0;
            bus.prog_we = 0;
            chk($sformatf("%s[%0d]", name, i), 32'(obs), 32'(tv[i].exp));
            if (tv[i].exp[2]) nb++;
        end
        bus.stall = 0;
`ifdef TPU_SEQ_PERF_EN
        if (!tv[n-1].exp[2]) chk({name, ".perf"}, bus.perf_cycles, 32'(nb));
`endif
    endtask

    task automatic prog_a();
        wr(0, ins(LOAD_ADDR, 13'h0123));
        wr(1, ins(LOAD_WEIGHT, 0));
        wr(2, ins(LOAD_INPUTS, 0));
        wr(3, ins(COMPUTE, 0));
        wr(4, ins(STORE, 0));
        wr(5, ins(HALT, 0));
    endtask

    function automatic void trace_a();
        tv.delete();
        push(3, 0, B);
        push(1, 0, LW);
        push(1, 0, B);
        push(1, 0, LI);
        push(1, 0, B);
        push(6, 0, V);
        push(1, 0, B);
        push(1, 0, ST);
        push(2, 0, B);
        push(2, 0, D);
    endfunction

    initial begin
        bus.start = 0; bus.prog_we = 0; bus.stall = 0; bus.prog_addr = 0; bus.prog_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 32'(obs), 32'(Z));
        chk("reset_base", 32'(bus.base_address), 0);
        reset = 0;
        @(posedge clk);
        #1 chk("idle_out", 32'(obs), 32'(Z));

        prog_a();
        trace_a();
        bus.start = 1;
        run("prog_a", 19);
        chk("base_a", 32'(bus.base_address), 32'h123);

        wr(0, ins(COMPUTE, 13'd3));
        wr(1, ins(HALT, 0));
        tv.delete();
        push(1, 0, B);
        push(2, 0, V);
        push(2, 1, V);
        push(1, 0, V);
        push(2, 0, B);
        push(1, 0, D);
        bus.start = 1;
        run("stall", 9);
        chk("base_hold", 32'(bus.base_address), 32'h123);

        wr(0, ins(LOAD_WEIGHT, 0));
        wr(1, ins(LOAD_INPUTS, 0));
        wr(2, ins(ILLEGAL, 0));
        wr(3, ins(STORE, 0));
        tv.delete();
        push(1, 0, B);
        push(1, 0, LW);
        push(1, 0, B);
        push(1, 0, LI);
        push(2, 0, B);
        push(3, 0, E);
        bus.start = 1;
        run("illegal", 9);
        bus.start = 1;
        run("illegal_rerun", 9);

        for (int i = 0; i < 16; i++) wr(i, ins(NOP, 0));
        tv.delete();
        push(32, 0, B);
        push(3, 0, D);
        bus.start = 1;
        run("nop16", 35);

        prog_a();
        trace_a();
        bus.start = 1;
        run("pre_reset", 9);
        #2 reset = 1;
        #1;
        chk("reset_async_out", 32'(obs), 32'(Z));
        chk("reset_async_base", 32'(bus.base_address), 0);
        @(posedge clk);
        #1 chk("reset_hold_out", 32'(obs), 32'(Z));
        reset = 0;
        #1 chk("post_reset_out", 32'(obs), 32'(Z));

        trace_a();
        tv[4].we = 1;
        bus.prog_addr = 5;
        bus.prog_data = ins(NOP, 0);
        bus.start = 1;
        run("rerun_a", 19);
        chk("rerun_base", 32'(bus.base_address), 32'h123);
        trace_a();
        bus.start = 1;
        run("we_busy", 19);

        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        bus.prog_addr = 0;
        bus.prog_data = ins(HALT, 0);
        tv.delete();
        push(1, 0, B, 1);
        push(1, 0, B);
        push(2, 0, D);
        bus.start = 1;
        run("we_start", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
